// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: datapath sizing, ALU opcodes, FSM states.
package alu_issue_ctrl_pkg;

    localparam int unsigned DW   = 20;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Local operand register file: two asynchronous read ports, one write port, cleared on reset.
module alu_regfile #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Request-side sequencer for the external 20-bit ALU: operand fetch, issue, writeback and response.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_ra,
    input  logic [AW-1:0] req_rb,
    input  logic [AW-1:0] req_rd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_carry,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_carry,
    output logic          rsp_dz
);

    state_t        state;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] res_q;
    logic          carry_q;
    logic          dz_q;
    logic          rsp_valid_q;

    logic          div_zero;
    logic [DW-1:0] res_next;
    logic [DW-1:0] rf_rdata_a;
    logic [DW-1:0] rf_rdata_b;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    // Handshake readies are gated by rst_n so both read 0 while reset is held.
    assign ld_ready  = rst_n & (state == ST_IDLE) & ld_en;
    assign req_ready = rst_n & (state == ST_IDLE) & ~ld_en;

    assign div_zero = (op_q == OP_DIV) && (opb_q == '0);
    assign res_next = div_zero ? '1 : alu_res;

    // Load (IDLE only) and writeback (ISSUE only) share the single write port.
    assign rf_we    = ld_ready | (state == ST_ISSUE);
    assign rf_waddr = (state == ST_ISSUE) ? rd_q : ld_addr;
    assign rf_wdata = (state == ST_ISSUE) ? res_next : ld_data;

    alu_regfile #(
        .WIDTH  (DW),
        .DEPTH  (NREG),
        .ADDR_W (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (req_ra),
        .rdata_a (rf_rdata_a),
        .raddr_b (req_rb),
        .rdata_b (rf_rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            dz_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q  <= req_op;
                        rd_q  <= req_rd;
                        opa_q <= rf_rdata_a;
                        opb_q <= rf_rdata_b;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_q       <= res_next;
                    dz_q        <= div_zero;
                    carry_q     <= alu_carry;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_sel   = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign rsp_carry = carry_q;
    assign rsp_dz    = dz_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a transaction-level response model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = '0;
    logic [AW-1:0] req_ra = '0;
    logic [AW-1:0] req_rb = '0;
    logic [AW-1:0] req_rd = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry;
    logic          rsp_dz;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_rd    (req_rd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_dz    (rsp_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] data;
        logic [2:0]    op;
        logic [AW-1:0] rd;
        logic          carry;
        logic          dz;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] model_rf [NREG];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] got_data;
    logic          got_carry;
    logic          got_dz;

    // Stand-in for the external ALU; div by zero returns junk the controller must replace.
    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return (b == 0) ? 20'h12345 : a / b;
        endcase
    endfunction

    function automatic logic carry_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW];
    endfunction

    always_comb begin
        alu_res   = alu_f(alu_sel, alu_a, alu_b);
        alu_carry = carry_f(alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle a response is presented, it must match the oldest outstanding transaction.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            chk("rsp_outstanding", expq.size(), 1);
            if (expq.size() != 0) begin
                chk("rsp_data",  rsp_data,  expq[0].data);
                chk("rsp_carry", rsp_carry, expq[0].carry);
                chk("rsp_dz",    rsp_dz,    expq[0].dz);
                chk("alu_a",     alu_a,     expq[0].a);
                chk("alu_b",     alu_b,     expq[0].b);
                chk("alu_sel",   alu_sel,   expq[0].op);
                if (rsp_ready) begin
                    model_rf[expq[0].rd] = expq[0].data;
                    void'(expq.pop_front());
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        #1;
        chk("ld_ready_idle", ld_ready, 1);
        chk("req_ready_under_ld", req_ready, 0);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        model_rf[a] = d;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] rd, input int hold);
        exp_t e;
        int   w;
        req_valid = 1'b1;
        req_op = op;
        req_ra = ra;
        req_rb = rb;
        req_rd = rd;
        rsp_ready = (hold == 0);
        #1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("req_accept_wait", req_ready, 1);
        e.a = model_rf[ra];
        e.b = model_rf[rb];
        e.op = op;
        e.rd = rd;
        e.dz = (op == OP_DIV) && (e.b == 0);
        e.data = e.dz ? {DW{1'b1}} : alu_f(op, e.a, e.b);
        e.carry = carry_f(e.a, e.b);
        expq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("lat_issue_no_rsp", rsp_valid, 0);
        chk("req_ready_issue", req_ready, 0);
        @(posedge clk);
        #1;
        chk("lat_rsp_valid", rsp_valid, 1);
        chk("writeback_rd", dut.u_rf.regs[rd], e.data);
        got_data = rsp_data;
        got_carry = rsp_carry;
        got_dz = rsp_dz;
        for (int i = 0; i < hold; i++) begin
            ld_en = 1'b1;
            ld_addr = rd ^ 3'd1;
            ld_data = 20'h55555;
            req_valid = 1'b1;
            #1;
            chk("ld_ready_resp", ld_ready, 0);
            chk("req_ready_resp", req_ready, 0);
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        chk("expq_drained", expq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREG; i++) model_rf[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        for (int i = 0; i < NREG; i++) chk("rst_regfile", dut.u_rf.regs[i], 0);
        @(posedge clk);
        #1;

        load(3'd1, 20'h00005);
        load(3'd2, 20'h00003);
        do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 0);
        chk("lit_add_5_3", got_data, 20'h00008);
        chk("lit_add_5_3_carry", got_carry, 0);
        chk("lit_r3", dut.u_rf.regs[3], 20'h00008);

        load(3'd1, 20'hFFFFF);
        load(3'd2, 20'h00001);
        do_op(OP_ADD, 3'd1, 3'd2, 3'd5, 0);
        chk("lit_add_wrap", got_data, 20'h00000);
        chk("lit_add_wrap_carry", got_carry, 1);
        do_op(OP_SUB, 3'd2, 3'd1, 3'd6, 0);
        chk("lit_sub_wrap", got_data, 20'h00002);

        do_op(OP_DIV, 3'd1, 3'd0, 3'd4, 0);
        chk("lit_div0_data", got_data, 20'hFFFFF);
        chk("lit_div0_dz", got_dz, 1);
        chk("lit_r4", dut.u_rf.regs[4], 20'hFFFFF);

        load(3'd1, 20'h00009);
        load(3'd2, 20'h00003);
        do_op(OP_DIV, 3'd1, 3'd2, 3'd5, 0);
        chk("lit_div_9_3", got_data, 20'h00003);
        chk("lit_div_9_3_dz", got_dz, 0);
        do_op(OP_MUL, 3'd1, 3'd2, 3'd7, 0);
        chk("lit_mul_9_3", got_data, 20'h0001B);
        do_op(OP_NOR, 3'd1, 3'd2, 3'd0, 0);
        do_op(OP_AND, 3'd1, 3'd2, 3'd0, 0);

        // Backpressure with a refused load to rd^1 (r7) during RESP.
        do_op(OP_XOR, 3'd1, 3'd2, 3'd6, 5);
        chk("lit_xor_9_3", got_data, 20'h0000A);
        chk("ignored_ld_r7", dut.u_rf.regs[7], model_rf[7]);
        chk("ignored_ld_r7_lit", dut.u_rf.regs[7], 20'h0001B);

        // Load and request in the same IDLE cycle: load first, request reads new value.
        ld_en = 1'b1;
        ld_addr = 3'd7;
        ld_data = 20'h00ABC;
        req_valid = 1'b1;
        req_op = OP_OR;
        req_ra = 3'd7;
        req_rb = 3'd7;
        req_rd = 3'd0;
        #1;
        chk("coll_ld_ready", ld_ready, 1);
        chk("coll_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        model_rf[7] = 20'h00ABC;
        do_op(OP_OR, 3'd7, 3'd7, 3'd0, 0);
        chk("lit_coll_or", got_data, 20'h00ABC);

        // Reset pulse while the op is in ISSUE.
        req_valid = 1'b1;
        req_op = OP_ADD;
        req_ra = 3'd1;
        req_rb = 3'd2;
        req_rd = 3'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("pre_rst_in_issue", req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_no_wb", dut.u_rf.regs[3], 0);
        @(posedge clk);
        #1;
        chk("mid_rst_no_wb_edge", dut.u_rf.regs[3], 0);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) model_rf[i] = '0;
        #1;
        chk("post_mid_rst_idle", req_ready, 1);
        chk("post_mid_rst_alu_sel", alu_sel, 0);
        @(posedge clk);
        #1;
        load(3'd1, 20'h00100);
        do_op(OP_ADD, 3'd1, 3'd1, 3'd2, 0);
        chk("lit_recover_add", got_data, 20'h00200);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
